onehot_debounce_8: RTL and testbench

ONEHOT_DEBOUNCE_8 -- requirements
Module: onehot_debounce_8

---
 rtl/onehot_debounce_8_if.sv | 18 +
 rtl/onehot_debounce_8.sv | 131 +++++++++++++
 tb/tb_onehot_debounce_8.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/onehot_debounce_8_if.sv
// rtl/onehot_debounce_8_if.sv - committed-code bus from the debouncer to the 8-to-3 encoder
//   d     : 8-bit one-hot committed code
//   valid : one-cycle strobe marking a new committed d
//   err   : one-cycle strobe on a settled multi-hot value (only with ONEHOT_ERR_EN)
// master modport drives the bus (debouncer), slave modport observes it (encoder side).
interface onehot_debounce_8_if;
  logic [7:0] d;
  logic       valid;
`ifdef ONEHOT_ERR_EN
  logic       err;

  modport master (output d, output valid, output err);
  modport slave  (input  d, input  valid, input  err);
`else
  modport master (output d, output valid);
  modport slave  (input  d, input  valid);
`endif
endinterface

// File: rtl/onehot_debounce_8.sv
// rtl/onehot_debounce_8.sv - synchronizing debouncer that commits one-hot request codes
//   Parameter DEBOUNCE_CYCLES (2..255): clocks the synchronized input must stay constant.
//   Ports:
//     clk    : single clock, rising edge
//     rst_n  : asynchronous active-low reset
//     raw    : 8 asynchronous request lines
//     cmt    : onehot_debounce_8_if.master (d, valid, err)
//   Macro ONEHOT_ERR_EN: when defined, cmt.err pulses for a settled multi-hot value;
//   when undefined the err signal and its logic are absent and multi-hot values are dropped.
module onehot_debounce_8 #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 raw,
  onehot_debounce_8_if.master        cmt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] cand, cand_n;
  logic [7:0] cnt, cnt_n;
  state_t     state, state_n;
  logic [7:0] d_q, d_n;
  logic       valid_q, valid_n;
  logic       cand_onehot;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign cand_onehot = (cand != 8'h00) && ((cand & (cand - 8'd1)) == 8'h00);

`ifdef ONEHOT_ERR_EN
  logic err_q, err_n;
  logic cand_multi;

  assign cand_multi = (cand != 8'h00) && !cand_onehot;
`endif

  // Two-flop synchronizer; nothing downstream sees raw directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cand    <= 8'h00;
      cnt     <= 8'h00;
      d_q     <= 8'h01;
      valid_q <= 1'b0;
`ifdef ONEHOT_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      cnt     <= cnt_n;
      d_q     <= d_n;
      valid_q <= valid_n;
`ifdef ONEHOT_ERR_EN
      err_q   <= err_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    d_n     = d_q;
    valid_n = 1'b0;
`ifdef ONEHOT_ERR_EN
    err_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sync2 != cand) begin
          cand_n  = sync2;
          cnt_n   = 8'h00;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2 != cand) begin
          // Input moved before settling: restart the window on the new value.
          cand_n = sync2;
          cnt_n  = 8'h00;
        end else if (cnt == CNT_LAST) begin
          state_n = COMMIT;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      COMMIT: begin
        // Single-cycle decision; zero, unchanged and multi-hot values leave d alone
        // so d is one-hot from reset onward.
        state_n = IDLE;
        if (cand_onehot && (cand != d_q)) begin
          d_n     = cand;
          valid_n = 1'b1;
        end
`ifdef ONEHOT_ERR_EN
        err_n = cand_multi;
`endif
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign cmt.d     = d_q;
  assign cmt.valid = valid_q;
`ifdef ONEHOT_ERR_EN
  assign cmt.err   = err_q;
`endif

endmodule

// File: tb/tb_onehot_debounce_8.sv
// tb/tb_onehot_debounce_8.sv - scoreboard bench for onehot_debounce_8 with DEBOUNCE_CYCLES=4
module tb_onehot_debounce_8;

  localparam int DC  = 4;
  localparam int LAT = DC + 4;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] raw;
  int         cyc;
  int         checks;
  int         errors;

  exp_t vq[$];
`ifdef ONEHOT_ERR_EN
  int   eq[$];
`endif

  onehot_debounce_8_if bus ();

  onehot_debounce_8 #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw),
    .cmt   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] o;
    o = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) o = 3'(i);
    return o;
  endfunction

  // Advance n rising edges, then step off the edge before driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_valid(input logic [7:0] dv, input int at);
    exp_t e;
    e.d   = dv;
    e.cyc = at;
    vq.push_back(e);
  endtask

  // Output monitor on the falling edge: every valid/err must match a queued expectation.
  always @(negedge clk) begin
    check("d_onehot", {31'b0, $onehot(bus.d)}, 32'd1);
    if (bus.valid) begin
      if (vq.size() == 0) begin
        check("valid_unexpected", {31'b0, bus.valid}, 32'd0);
      end else begin
        exp_t e;
        e = vq.pop_front();
        check("valid_d", {24'b0, bus.d}, {24'b0, e.d});
        check("valid_cycle", cyc, e.cyc);
      end
    end
`ifdef ONEHOT_ERR_EN
    if (bus.err) begin
      if (eq.size() == 0) begin
        check("err_unexpected", {31'b0, bus.err}, 32'd0);
      end else begin
        int ec;
        ec = eq.pop_front();
        check("err_cycle", cyc, ec);
      end
    end
`endif
  end

  initial begin
    int last;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    raw    = 8'h00;

    // Reset state.
    tick(3);
    check("reset_d", {24'b0, bus.d}, 32'h01);
    check("reset_valid", {31'b0, bus.valid}, 32'd0);
    rst_n = 1'b1;

    // Idle input for 50 cycles: nothing commits.
    tick(50);
    check("idle_d", {24'b0, bus.d}, 32'h01);

    // Clean press of line 3.
    raw = 8'h08;
    expect_valid(8'h08, cyc + LAT);
    tick(LAT + 4);
    check("press_d", {24'b0, bus.d}, 32'h08);
    check("press_enc", {29'b0, enc(bus.d)}, 32'd3);

    // Short glitch to line 5 that returns to the committed code.
    raw = 8'h20;
    tick(3);
    raw = 8'h08;
    tick(LAT + 6);
    check("glitch_d", {24'b0, bus.d}, 32'h08);

    // Bouncing line 4 followed by a stable hold.
    last = 0;
    for (int i = 0; i < 6; i++) begin
      raw = (i % 2 == 0) ? 8'h10 : 8'h00;
      tick(2);
    end
    raw  = 8'h10;
    last = cyc;
    expect_valid(8'h10, last + LAT);
    tick(LAT + 6);
    check("bounce_d", {24'b0, bus.d}, 32'h10);
    check("bounce_enc", {29'b0, enc(bus.d)}, 32'd4);

    // Multi-hot value is never committed.
    raw = 8'h41;
`ifdef ONEHOT_ERR_EN
    eq.push_back(cyc + LAT);
`endif
    tick(LAT + 6);
    check("multihot_d", {24'b0, bus.d}, 32'h10);

    // Reset arriving mid-settle aborts the commit; a full settle follows release.
    raw = 8'h80;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("midrst_d", {24'b0, bus.d}, 32'h01);
    check("midrst_valid", {31'b0, bus.valid}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    expect_valid(8'h80, cyc + LAT);
    tick(LAT - 1);
    check("postrst_early_d", {24'b0, bus.d}, 32'h01);
    tick(7);
    check("postrst_d", {24'b0, bus.d}, 32'h80);
    check("postrst_enc", {29'b0, enc(bus.d)}, 32'd7);

    // Release to all-zero keeps the last code.
    raw = 8'h00;
    tick(LAT + 6);
    check("release_d", {24'b0, bus.d}, 32'h80);

    check("valid_q_drained", vq.size(), 32'd0);
`ifdef ONEHOT_ERR_EN
    check("err_q_drained", eq.size(), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
